// File: rtl/mii_baser_66b_encoder_pkg.sv
// baser_pkg: BASE-R lane characters, control codes, sync headers, block types and enums.
package baser_pkg;
    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_ERROR = 8'hFE;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_SEQ   = 8'h9C;
    localparam logic [6:0] CTRL_IDLE  = 7'h00;
    localparam logic [6:0] CTRL_ERROR = 7'h1E;
    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;
    localparam logic [7:0] BT_C = 8'h1E;
    localparam logic [7:0] BT_S = 8'h78;
    localparam logic [7:0] BT_O = 8'h4B;
    // Terminate block types, byte k belongs to T_k.
    localparam logic [63:0] BT_T = {8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87};
    localparam logic [65:0] IDLE_BLOCK = {56'h0, BT_C, SYNC_CTRL};
    localparam logic [65:0] ERR_BLOCK  = {{8{CTRL_ERROR}}, BT_C, SYNC_CTRL};
    typedef enum logic [1:0] {TX_INIT, TX_C, TX_D, TX_E} tx_state_t;
    typedef enum logic [2:0] {CLS_C, CLS_S, CLS_O, CLS_D, CLS_T, CLS_E} blk_class_t;
    function automatic logic [6:0] ctrl_code(input logic [7:0] ch);
        return ch == MII_IDLE ? CTRL_IDLE : CTRL_ERROR;
    endfunction
endpackage

// File: rtl/mii_baser_66b_encoder_block_builder.sv
// mii_66b_block_builder: classifies one MII word and forms its candidate 66b block.
module mii_66b_block_builder
    import baser_pkg::*;
(
    input  logic [63:0] txd_i,
    input  logic [7:0]  txc_i,
    output blk_class_t  cls_o,
    output logic [65:0] block_o
);
    logic [7:0]  is_ic;
    logic [7:0]  t_ok;
    logic [55:0] codes;
    logic [55:0] t_pay;
    logic [7:0]  t_type;
    logic        c_ok;
    logic        s_ok;
    logic        o_ok;
    logic        d_ok;
    // Lane j's 7b code sits at [10+7j] in both C and T blocks, so one code vector serves both.
    always_comb begin
        is_ic  = '0;
        codes  = '0;
        t_ok   = '0;
        t_pay  = '0;
        t_type = '0;
        for (int i = 0; i < 8; i++) begin
            is_ic[i] = txd_i[8*i +: 8] == MII_IDLE || txd_i[8*i +: 8] == MII_ERROR;
            codes[7*i +: 7] = ctrl_code(txd_i[8*i +: 8]);
        end
        for (int k = 0; k < 8; k++) begin
            t_ok[k] = txc_i == 8'hFF << k && txd_i[8*k +: 8] == MII_TERM && &(is_ic | ~(8'hFE << k));
            if (t_ok[k]) begin
                t_type = BT_T[8*k +: 8];
                for (int i = 0; i < 7; i++)
                    if (i < k) t_pay[8*i +: 8] = txd_i[8*i +: 8];
                for (int i = 1; i < 8; i++)
                    if (i > k) t_pay[7*i +: 7] = codes[7*i +: 7];
            end
        end
    end
    assign c_ok = txc_i == 8'hFF && &is_ic;
    assign s_ok = txc_i == 8'h01 && txd_i[7:0] == MII_START;
    assign o_ok = txc_i == 8'hF1 && txd_i[7:0] == MII_SEQ && txd_i[63:32] == {4{MII_IDLE}};
    assign d_ok = txc_i == 8'h00;
    assign cls_o = c_ok ? CLS_C : s_ok ? CLS_S : o_ok ? CLS_O : d_ok ? CLS_D : |t_ok ? CLS_T : CLS_E;
    assign block_o = c_ok  ? {codes, BT_C, SYNC_CTRL} :
                     s_ok  ? {txd_i[63:8], BT_S, SYNC_CTRL} :
                     o_ok  ? {28'h0, 4'h0, txd_i[31:8], BT_O, SYNC_CTRL} :
                     d_ok  ? {txd_i, SYNC_DATA} :
                     |t_ok ? {t_pay, t_type, SYNC_CTRL} : ERR_BLOCK;
endmodule

// File: rtl/mii_baser_66b_encoder.sv
// mii_baser_66b_encoder: 64b MII to 66b BASE-R transmit encoder with block counters.
module mii_baser_66b_encoder
    import baser_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_txd,
    input  logic [CTRL_WIDTH-1:0]  i_txc,
    output logic [FRAME_WIDTH-1:0] o_tx_coded,
    output logic                   o_valid,
    output logic [31:0]            o_block_count,
    output logic [31:0]            o_data_count,
    output logic [31:0]            o_ctrl_count,
    output logic [31:0]            o_err_count
);
    tx_state_t               state_q, state_d;
    blk_class_t              cls;
    logic [FRAME_WIDTH-1:0]  cand, coded_q, coded_d;
    logic                    valid_q, err;
    logic [31:0]             blk_q, blk_d, data_q, data_d, ctrl_q, ctrl_d, err_q, err_d;
    mii_66b_block_builder u_builder (
        .txd_i   (i_txd),
        .txc_i   (i_txc),
        .cls_o   (cls),
        .block_o (cand)
    );
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= TX_INIT;
            coded_q <= IDLE_BLOCK;
            valid_q <= 1'b0;
            blk_q   <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            coded_q <= coded_d;
            valid_q <= i_valid;
            blk_q   <= blk_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
        end
    end
    // Ordered sets travel like idles; only a word landing in TX_E is replaced by the error block.
    always_comb begin
        state_d = state_q;
        if (i_valid)
            case (state_q)
                TX_INIT, TX_C: state_d = cls inside {CLS_C, CLS_O} ? TX_C : cls == CLS_S ? TX_D : TX_E;
                TX_D:          state_d = cls == CLS_D ? TX_D : cls == CLS_T ? TX_C : TX_E;
                default:       state_d = cls inside {CLS_D, CLS_S} ? TX_D : cls == CLS_E ? TX_E : TX_C;
            endcase
    end
    always_comb begin
        err     = i_valid && state_d == TX_E;
        coded_d = !i_valid ? coded_q : err ? ERR_BLOCK : cand;
        blk_d   = blk_q + 32'(i_valid);
        data_d  = data_q + 32'(i_valid && coded_d[HDR_WIDTH-1:0] == SYNC_DATA);
        ctrl_d  = ctrl_q + 32'(i_valid && coded_d[HDR_WIDTH-1:0] == SYNC_CTRL);
        err_d   = err_q + 32'(err);
    end
    assign o_tx_coded    = coded_q;
    assign o_valid       = valid_q;
    assign o_block_count = blk_q;
    assign o_data_count  = data_q;
    assign o_ctrl_count  = ctrl_q;
    assign o_err_count   = err_q;
endmodule

// File: tb/tb_mii_baser_66b_encoder.sv
// tb_mii_baser_66b_encoder: directed and random checks against a table-driven reference encoder.
module tb_mii_baser_66b_encoder;
    localparam logic [65:0] IDLE_BLK = {56'h0, 8'h1E, 2'b01};
    localparam logic [65:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E, 2'b01};
    localparam logic [7:0] T_TYPE [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    // Next state indexed [state][class]; states INIT,C,D,E = 0..3; classes C,S,O,D,T,E = 0..5.
    localparam int NXT [4][6] = '{'{1, 2, 1, 3, 3, 3}, '{1, 2, 1, 3, 3, 3},
                                  '{3, 3, 3, 2, 1, 3}, '{1, 2, 1, 2, 1, 3}};
    logic        clk, i_rst, i_valid, o_valid;
    logic [63:0] i_txd;
    logic [7:0]  i_txc;
    logic [65:0] o_tx_coded;
    logic [31:0] o_block_count, o_data_count, o_ctrl_count, o_err_count;
    int          m_state, passed, fails, total;
    logic [65:0] m_coded;
    logic        m_valid;
    logic [31:0] m_blk, m_data, m_ctrl, m_err;
    mii_baser_66b_encoder dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_txd         (i_txd),
        .i_txc         (i_txc),
        .o_tx_coded    (o_tx_coded),
        .o_valid       (o_valid),
        .o_block_count (o_block_count),
        .o_data_count  (o_data_count),
        .o_ctrl_count  (o_ctrl_count),
        .o_err_count   (o_err_count)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    function automatic bit is_ic(input logic [7:0] b);
        return b == 8'h07 || b == 8'hFE;
    endfunction
    function automatic logic [6:0] code7(input logic [7:0] b);
        return b == 8'h07 ? 7'h00 : 7'h1E;
    endfunction
    function automatic logic [7:0] ic_byte();
        return $urandom_range(0, 1) ? 8'h07 : 8'hFE;
    endfunction
    task automatic classify(input logic [63:0] d, input logic [7:0] c, output int cls, output int k);
        logic [7:0] b [8];
        bit all_ic, hi_idle, ok;
        all_ic = 1;
        hi_idle = 1;
        for (int i = 0; i < 8; i++) begin
            b[i] = d[8*i +: 8];
            if (!is_ic(b[i])) all_ic = 0;
            if (i >= 4 && b[i] != 8'h07) hi_idle = 0;
        end
        cls = 5;
        k = 0;
        if (c == 8'hFF && all_ic) cls = 0;
        else if (c == 8'h01 && b[0] == 8'hFB) cls = 1;
        else if (c == 8'hF1 && b[0] == 8'h9C && hi_idle) cls = 2;
        else if (c == 8'h00) cls = 3;
        else
            for (int t = 0; t < 8; t++) begin
                ok = c == 8'(8'hFF << t) && b[t] == 8'hFD;
                for (int j = t + 1; j < 8; j++) if (!is_ic(b[j])) ok = 0;
                if (ok) begin
                    cls = 4;
                    k = t;
                end
            end
    endtask
    function automatic logic [65:0] encode(input int cls, input int k, input logic [63:0] d);
        logic [65:0] r;
        logic [48:0] top;
        case (cls)
            0: begin
                r = IDLE_BLK;
                for (int i = 0; i < 8; i++) r |= 66'(code7(d[8*i +: 8])) << (10 + 7*i);
            end
            1: r = {d[63:8], 8'h78, 2'b01};
            2: r = {32'h0, d[31:8], 8'h4B, 2'b01};
            3: r = {d, 2'b10};
            4: begin
                r = {56'h0, T_TYPE[k], 2'b01};
                for (int i = 0; i < k; i++) r |= 66'(d[8*i +: 8]) << (10 + 8*i);
                top = '0;
                for (int j = k + 1; j < 8; j++) top |= 49'(code7(d[8*j +: 8])) << (7*(j - k - 1));
                if (k < 7) r |= 66'(top) << (66 - 7*(7 - k));
            end
            default: r = ERR_BLK;
        endcase
        return r;
    endfunction
    task automatic decode(input logic [65:0] b, output logic [63:0] d, output logic [7:0] c);
        d = '0;
        c = 8'hAA;
        if (b[1:0] == 2'b10) begin
            d = b[65:2];
            c = 8'h00;
        end else
            for (int k = 0; k < 8; k++)
                if (b[9:2] == T_TYPE[k]) begin
                    c = 8'hFF << k;
                    for (int i = 0; i < 8; i++)
                        d[8*i +: 8] = i < k ? b[10 + 8*i +: 8] : i == k ? 8'hFD :
                                      b[10 + 7*i +: 7] == 7'h00 ? 8'h07 : 8'hFE;
                end
    endtask
    task automatic gen_t(input int k, output logic [63:0] d, output logic [7:0] c);
        d = {$urandom, $urandom};
        for (int i = 0; i < 8; i++)
            if (i == k) d[8*i +: 8] = 8'hFD;
            else if (i > k) d[8*i +: 8] = ic_byte();
        c = 8'hFF << k;
    endtask
    task automatic gen(input int kind, output logic [63:0] d, output logic [7:0] c);
        d = {$urandom, $urandom};
        c = 8'h00;
        case (kind)
            0, 1: begin
                for (int i = 0; i < 8; i++) d[8*i +: 8] = ic_byte();
                c = 8'hFF;
            end
            2: begin d[7:0] = 8'hFB; c = 8'h01; end
            3: begin d[7:0] = 8'h9C; d[63:32] = {4{8'h07}}; c = 8'hF1; end
            4, 5, 6: c = 8'h00;
            7, 8: gen_t(int'($urandom_range(0, 7)), d, c);
            default: c = 8'($urandom);
        endcase
    endtask
    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic check_all(input string tag);
        check({tag, ".coded"}, o_tx_coded, m_coded);
        check({tag, ".valid"}, 66'(o_valid), 66'(m_valid));
        check({tag, ".blk"}, 66'(o_block_count), 66'(m_blk));
        check({tag, ".data"}, 66'(o_data_count), 66'(m_data));
        check({tag, ".ctrl"}, 66'(o_ctrl_count), 66'(m_ctrl));
        check({tag, ".err"}, 66'(o_err_count), 66'(m_err));
    endtask
    task automatic model_reset();
        m_state = 0;
        m_coded = IDLE_BLK;
        m_valid = 0;
        m_blk = 0;
        m_data = 0;
        m_ctrl = 0;
        m_err = 0;
    endtask
    task automatic step(input logic v, input logic [63:0] d, input logic [7:0] c, input string tag);
        int cls, k, nxt;
        i_valid = v;
        i_txd = d;
        i_txc = c;
        @(posedge clk);
        #1;
        if (v) begin
            classify(d, c, cls, k);
            nxt = NXT[m_state][cls];
            m_coded = nxt == 3 ? ERR_BLK : encode(cls, k, d);
            m_blk++;
            if (m_coded[1:0] == 2'b10) m_data++;
            else m_ctrl++;
            if (nxt == 3) m_err++;
            m_state = nxt;
        end
        m_valid = v;
        check_all(tag);
    endtask
    initial begin
        logic [63:0] d, rd;
        logic [7:0]  c, rc;
        passed = 0;
        fails = 0;
        total = 0;
        i_rst = 1;
        i_valid = 0;
        i_txd = '0;
        i_txc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        i_rst = 0;
        repeat (4) step(1, {8{8'h07}}, 8'hFF, "idle");
        check("idle4.coded", o_tx_coded, IDLE_BLK);
        check("idle4.ctrl", 66'(o_ctrl_count), 66'd4);
        step(1, {{$urandom, 24'($urandom)}, 8'hFB}, 8'h01, "frame.s");
        check("frame.s.type", 66'(o_tx_coded[9:2]), 66'h78);
        repeat (3) step(1, {$urandom, $urandom}, 8'h00, "frame.d");
        d = {32'h07070707, 8'hFD, 24'($urandom)};
        step(1, d, 8'hF8, "frame.t3");
        check("frame.t3.type", 66'(o_tx_coded[9:2]), 66'hB4);
        check("frame.t3.data", 66'(o_tx_coded[33:10]), 66'(d[23:0]));
        check("frame.t3.codes", 66'(o_tx_coded[65:38]), 66'h0);
        check("frame.datacnt", 66'(o_data_count), 66'd3);
        check("frame.ctrlcnt", 66'(o_ctrl_count), 66'd6);
        for (int k = 0; k < 8; k++) begin
            step(1, {{$urandom, 24'($urandom)}, 8'hFB}, 8'h01, "sweep.s");
            step(1, {$urandom, $urandom}, 8'h00, "sweep.d");
            gen_t(k, d, c);
            step(1, d, c, "sweep.t");
            check("sweep.type", 66'(o_tx_coded[9:2]), 66'(T_TYPE[k]));
            decode(o_tx_coded, rd, rc);
            check("sweep.rt_txd", 66'(rd), 66'(d));
            check("sweep.rt_txc", 66'(rc), 66'(c));
        end
        step(1, {8{8'h07}}, 8'hFF, "dinc.idle");
        step(1, {$urandom, $urandom}, 8'h00, "dinc.d");
        check("dinc.errblk", o_tx_coded, ERR_BLK);
        check("dinc.errcnt", 66'(o_err_count), 66'd1);
        step(1, {8{8'h07}}, 8'hFF, "dinc.recover");
        check("dinc.idleblk", o_tx_coded, IDLE_BLK);
        step(1, {{$urandom, 24'($urandom)}, 8'hFB}, 8'h01, "gap.s");
        step(1, {$urandom, $urandom}, 8'h00, "gap.d");
        repeat (3) step(0, {$urandom, $urandom}, 8'($urandom), "gap.hold");
        step(1, {$urandom, $urandom}, 8'h00, "gap.d2");
        gen_t(2, d, c);
        step(1, d, c, "gap.t2");
        step(1, {{$urandom, 24'($urandom)}, 8'hFB}, 8'h01, "rst.s");
        step(1, {$urandom, $urandom}, 8'h00, "rst.d");
        i_rst = 1;
        #1;
        model_reset();
        check_all("rst.async");
        @(posedge clk);
        #1;
        i_rst = 0;
        step(1, {$urandom, $urandom}, 8'h00, "rst.d_init");
        check("rst.errblk", o_tx_coded, ERR_BLK);
        repeat (400) begin
            gen(int'($urandom_range(0, 9)), d, c);
            step($urandom_range(0, 7) != 0, d, c, "rand");
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
